iis_tx_master: RTL and testbench
================================

# iis_tx_master

I2S master transmitter, clocked by the 49.152 MHz audio PLL divided output. It generates BCLK/LRCK for the codec at 48/96/192/384 kHz. It accepts stereo 32-bit sample pairs from the USB audio stream path over a valid/ready handshake and serialises them MSB-first in standard I2S format with 64 BCLKs per frame. It sits between the audio sample FIFO upstream and the external DAC pins downstream.

## Interface
Parameters
- DATA_W, default 32: sample slot width. Fixed at 32; the frame is 2×DATA_W bits.

Ports
- clk  in  1  49.152 MHz PLL-divided clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  transmitter enable; level-sensitive.
- sr_sel  in  2  rate select. Half-period H = 1<<sr_sel clk cycles; fs = 384 kHz/H (0→384k, 1→192k, 2→96k, 3→48k).
- s_valid  in  1  a sample pair is offered.
- s_ready  out  1  the block can accept a pair.
- s_left  in  DATA_W  left sample, MSB-justified.
- s_right  in  DATA_W  right sample, MSB-justified.
- bclk_o  out  1  bit clock.
- lrck_o  out  1  word select; 0 = left, 1 = right.
- sdata_o  out  1  serial data.
- underrun_o  out  1  one-cycle pulse when a frame load finds no sample.
- underrun_cnt_o  out  16  present only with IIS_TX_UNDERRUN_CNT_EN.

## Operation
- **Reset (rst_n=0)**
  - bclk_o, lrck_o, sdata_o, underrun_o = 0; underrun_cnt_o = 0.
  - s_ready = 1; buffer empty; shifter = 0.
  - hc = 0; bit_cnt = 63.
- **Clock divider**
  - hc counts 0..H-1. At hc==H-1, bclk_o toggles and hc returns to 0.
  - A 1→0 transition of bclk_o is the "fall event".
- **Bit counter**
  - bit_cnt (6 bits) increments by 1 on every fall event and wraps 63→0.
  - lrck_o = 0 for bit_cnt 0..31 and 1 for bit_cnt 32..63.
- **Frame load**
  - Occurs on the fall event where bit_cnt becomes 1.
  - Buffer full: shifter ← {left,right}; buffer cleared.
  - Buffer empty: shifter ← 0 and underrun_o pulses.
- **Shifting**
  - sdata_o = shifter[63], updated on every fall event; the shifter shifts left on fall events other than the load.
  - Result: the left MSB appears at bit_cnt=1 (one BCLK after LRCK falls), and the right LSB appears at bit_cnt=0 of the following frame.
- **Input buffer**
  - One pair. s_ready = !buf_full, registered.
  - A transfer occurs when s_valid && s_ready; buf_full sets in that cycle.
  - When a load clears the buffer, s_ready rises the next cycle. No same-cycle refill.
- **sr_sel**
  - Sampled only on the fall event where bit_cnt becomes 0.
  - A change mid-frame takes effect at the next frame boundary.
- **en = 0**
  - hc, bclk_o, lrck_o, sdata_o, shifter and bit_cnt are forced to their reset values synchronously.
  - The buffer and the handshake keep operating.
  - underrun_o does not pulse while disabled.
- **en rising**
  - The first bclk_o rise occurs H cycles later.
  - The first fall event is at 2H cycles: bit_cnt=0, sdata_o=0.
  - The first load is at 4H cycles.

## Timing
- All outputs are registered. bclk_o, lrck_o and sdata_o change in the same clk cycle, on fall events only.
- The codec samples sdata_o on the BCLK rising edge, so data is stable for H cycles before that edge.
- underrun_o is high for exactly one clk cycle, in the load cycle.
- Latency: a pair accepted at least one cycle before a load appears on sdata_o at that load.
- Frame length = 128·H clk cycles.

## Configuration
- IIS_TX_UNDERRUN_CNT_EN
  - Defined: underrun_cnt_o exists. It is a 16-bit counter, incremented on each underrun_o pulse, saturating at 0xFFFF, and cleared only by rst_n.
  - Undefined: neither the port nor the counter exists; all other behaviour is identical.

## Structure
- Shared package iis_pkg contains:
  - FRAME_BITS=64, SLOT_BITS=32.
  - A sr_sel enum (SR_384K, SR_192K, SR_96K, SR_48K).
  - A function mapping sr_sel to H.
- One sub-module, iis_bclk_div: hc counter, bclk_o register and fall-event strobe, with en and sr_sel latching. The shifter, buffer and counters stay in the top module.

## Test plan
- sr_sel=0, en=1, pair L=0x80000001, R=0x00000003 preloaded → BCLK period 2 clk, LRCK period 128 clk. Left bits appear MSB-first from bit_cnt=1; right bits 1 and 0 are 1, with the right LSB at bit_cnt=0 of the next frame.
- sr_sel=3, s_valid=1 continuously with an incrementing pattern → BCLK period 16 clk, fs = 48 kHz, no underrun_o over 10 frames, every pair transmitted once in order.
- No s_valid after reset → underrun_o pulses once per frame (every 128·H clk) and sdata_o stays 0. With the macro, underrun_cnt_o = 5 after 5 frames.
- Change sr_sel 0→2 at bit_cnt=20 → the current frame completes at H=1 and the next frame runs with BCLK period 8 clk.
- Drop en mid-frame → bclk_o, lrck_o, sdata_o go 0 the next cycle and a buffered pair is retained. On en rising, the retained pair is transmitted at the first load (4H cycles).
- Assert rst_n=0 asynchronously mid-frame with the buffer full → all outputs go 0 immediately, s_ready=1, and the buffered pair is discarded.

Source files
------------

// File: rtl/iis_pkg.sv
// Shared definitions for the I2S master transmitter: frame geometry, rate
// select encoding and the rate-to-half-period mapping.
package iis_pkg;

  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned SLOT_BITS  = 32;

  // Rate select; the encoding is the log2 of the BCLK half-period in clk cycles
  typedef enum logic [1:0] {
    SR_384K = 2'd0,
    SR_192K = 2'd1,
    SR_96K  = 2'd2,
    SR_48K  = 2'd3
  } sr_sel_e;

  // BCLK half-period H in clk cycles for a given rate select
  function automatic logic [3:0] half_period(input sr_sel_e sel);
    return 4'd1 << sel;
  endfunction

endpackage

// File: rtl/iis_bclk_div.sv
// BCLK generator: half-period counter, bclk register and fall-event strobe.
// The rate select is tracked while disabled and otherwise re-latched only on
// the fall event that starts a new frame, so a frame always runs at one rate.
module iis_bclk_div
  import iis_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] sr_sel_i,
  input  logic       frame_wrap_i, // bit counter is at its last bit
  output logic       bclk_o,
  output logic       fall_o
);

  logic [2:0] hc_q, hc_d;
  logic       bclk_q, bclk_d;
  sr_sel_e    sel_q, sel_d;
  logic [2:0] hc_last;

  assign hc_last = 3'(half_period(sel_q) - 4'd1);
  // Strobe is combinational so the top can update its outputs on the same edge
  assign fall_o  = en_i && bclk_q && (hc_q == hc_last);
  assign bclk_o  = bclk_q;

  // Next-state for the half-period counter, bclk and latched rate
  always_comb begin
    hc_d   = hc_q;
    bclk_d = bclk_q;
    sel_d  = sel_q;
    if (!en_i) begin
      hc_d   = 3'd0;
      bclk_d = 1'b0;
      sel_d  = sr_sel_e'(sr_sel_i);
    end else if (hc_q == hc_last) begin
      hc_d   = 3'd0;
      bclk_d = !bclk_q;
      if (bclk_q && frame_wrap_i) begin
        sel_d = sr_sel_e'(sr_sel_i);
      end
    end else begin
      hc_d = hc_q + 3'd1;
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q   <= 3'd0;
      bclk_q <= 1'b0;
      sel_q  <= SR_384K;
    end else begin
      hc_q   <= hc_d;
      bclk_q <= bclk_d;
      sel_q  <= sel_d;
    end
  end

endmodule

// File: rtl/iis_tx_master.sv
// I2S master transmitter: one-pair input buffer, 64-bit frame shifter, bit
// counter and word select, serialising MSB-first in standard I2S format.
// Optional feature: define IIS_TX_UNDERRUN_CNT_EN to add a saturating 16-bit
// underrun counter on underrun_cnt_o.
module iis_tx_master
  import iis_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        sr_sel,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bclk_o,
  output logic              lrck_o,
  output logic              sdata_o,
  output logic              underrun_o
`ifdef IIS_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt_o
`endif
);

  localparam int unsigned ShW = 2 * DATA_W;

  logic              fall, load;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic              lrck_q, lrck_d;
  logic [ShW-1:0]    sh_q, sh_d;
  logic              underrun_q, underrun_d;
  logic              buf_full_q, buf_full_d;
  logic              s_ready_q, s_ready_d;
  logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;

  iis_bclk_div u_bclk_div (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .sr_sel_i     (sr_sel),
    .frame_wrap_i (bit_cnt_q == 6'(FRAME_BITS - 1)),
    .bclk_o       (bclk_o),
    .fall_o       (fall)
  );

  // Load happens on the fall event that moves the bit counter to 1
  assign load       = fall && (bit_cnt_q == 6'd0);
  assign lrck_o     = lrck_q;
  assign sdata_o    = sh_q[ShW-1];
  assign underrun_o = underrun_q;
  assign s_ready    = s_ready_q;

  // Next-state for the frame datapath and the input buffer
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    lrck_d     = lrck_q;
    sh_d       = sh_q;
    underrun_d = 1'b0;
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;

    if (!en) begin
      bit_cnt_d = 6'(FRAME_BITS - 1);
      lrck_d    = 1'b0;
      sh_d      = '0;
    end else if (fall) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrck_d    = bit_cnt_d[5];
      if (load) begin
        if (buf_full_q) begin
          sh_d = {buf_l_q, buf_r_q};
        end else begin
          sh_d       = '0;
          underrun_d = 1'b1;
        end
      end else begin
        sh_d = {sh_q[ShW-2:0], 1'b0};
      end
    end

    // s_ready is low whenever the buffer is full, so load and accept never collide
    if (load && buf_full_q) begin
      buf_full_d = 1'b0;
    end else if (s_valid && s_ready_q) begin
      buf_full_d = 1'b1;
      buf_l_d    = s_left;
      buf_r_d    = s_right;
    end
    s_ready_d = !buf_full_d;
  end

  // Datapath and buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= 6'(FRAME_BITS - 1);
      lrck_q     <= 1'b0;
      sh_q       <= '0;
      underrun_q <= 1'b0;
      buf_full_q <= 1'b0;
      s_ready_q  <= 1'b1;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      sh_q       <= sh_d;
      underrun_q <= underrun_d;
      buf_full_q <= buf_full_d;
      s_ready_q  <= s_ready_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
    end
  end

`ifdef IIS_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  // Saturating count of underrun pulses, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= 16'd0;
    end else if (underrun_q && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_cnt_o = ucnt_q;
`endif

endmodule

// File: tb/tb_iis_tx_master.sv
// Directed self-checking bench for iis_tx_master.
module tb_iis_tx_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  sr_sel;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_left, s_right;
  logic        bclk_o, lrck_o, sdata_o, underrun_o;
`ifdef IIS_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  iis_tx_master #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sr_sel     (sr_sel),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_left     (s_left),
    .s_right    (s_right),
    .bclk_o     (bclk_o),
    .lrck_o     (lrck_o),
    .sdata_o    (sdata_o),
    .underrun_o (underrun_o)
`ifdef IIS_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_err = 0;
  int unsigned cyc = 0, fall_cnt = 0, last_fall_cyc = 0;
  int unsigned und_cnt = 0, und_run = 0, und_max_run = 0, und_last_cyc = 0, und_gap = 0;
  int unsigned feed_idx = 0;
  bit          fall_now = 1'b0;
  bit          feeding = 1'b0;
  logic        bclk_prev = 1'b0;

  // Edge monitor: 1 time unit after each rising clk edge
  always @(posedge clk) begin
    #1;
    cyc++;
    fall_now  = (bclk_prev === 1'b1) && (bclk_o === 1'b0);
    bclk_prev = bclk_o;
    if (fall_now) begin
      fall_cnt++;
      last_fall_cyc = cyc;
    end
    if (underrun_o === 1'b1) begin
      und_run++;
      if (und_run > und_max_run) und_max_run = und_run;
      if (und_cnt != 0) und_gap = cyc - und_last_cyc;
      und_last_cyc = cyc;
      und_cnt++;
    end else begin
      und_run = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    #1;
    rst_n   = 1'b0;
    en      = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Return 2 time units after the next rising edge that produced a BCLK fall
  task automatic next_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #2;
      if (fall_now) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("fall_timeout", {63'd0, ok}, 64'd1);
  endtask

  task automatic skip_to(input int unsigned fc0, input int unsigned n);
    bit ok;
    for (int i = 0; i < 200 && (fall_cnt - fc0) < n; i++) next_fall(ok);
    check_eq("skip_to", 64'(fall_cnt - fc0), 64'(n));
  endtask

  task automatic collect_frame(output logic [63:0] d, output logic [63:0] lr,
                               output int unsigned st);
    bit ok;
    d  = '0;
    lr = '0;
    st = 0;
    for (int k = 0; k < 64; k++) begin
      next_fall(ok);
      if (k == 0) st = last_fall_cyc;
      d[63-k]  = sdata_o;
      lr[63-k] = lrck_o;
    end
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    for (int i = 0; i < 2000; i++) begin
      if (s_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check_eq("push_accept", {63'd0, ok}, 64'd1);
  endtask

  task automatic enable(output int unsigned c0, output int unsigned fc0);
    @(posedge clk);
    #2;
    c0  = cyc;
    fc0 = fall_cnt;
    en  = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, lr, exp_lr, acc;
    int unsigned c0, fc0, st, st0, u0, g;
    bit          ok;

    rst_n = 1'b0; en = 1'b0; sr_sel = 2'd0; s_valid = 1'b0;
    s_left = '0; s_right = '0;
    for (int k = 0; k < 64; k++) exp_lr[63-k] = (((k + 1) % 64) >= 32);

    // Test 1: H=1, single preloaded pair
    do_reset();
    check_eq("rst_bclk", {63'd0, bclk_o}, 64'd0);
    check_eq("rst_lrck", {63'd0, lrck_o}, 64'd0);
    check_eq("rst_sdata", {63'd0, sdata_o}, 64'd0);
    check_eq("rst_underrun", {63'd0, underrun_o}, 64'd0);
    check_eq("rst_ready", {63'd0, s_ready}, 64'd1);
`ifdef IIS_TX_UNDERRUN_CNT_EN
    check_eq("rst_ucnt", {48'd0, underrun_cnt}, 64'd0);
`endif
    sr_sel = 2'd0;
    push(32'h8000_0001, 32'h0000_0003);
    check_eq("t1_ready_low", {63'd0, s_ready}, 64'd0);
    u0 = und_cnt;
    enable(c0, fc0);
    @(posedge clk);
    #2;
    check_eq("t1_first_rise", {63'd0, bclk_o}, 64'd1);
    next_fall(ok);
    check_eq("t1_first_fall_cyc", 64'(last_fall_cyc - c0), 64'd2);
    check_eq("t1_first_fall_sdata", {63'd0, sdata_o}, 64'd0);
    check_eq("t1_first_fall_lrck", {63'd0, lrck_o}, 64'd0);
    collect_frame(d, lr, st);
    check_eq("t1_load_cyc", 64'(st - c0), 64'd4);
    check_eq("t1_frame_data", d, 64'h8000_0001_0000_0003);
    check_eq("t1_frame_lrck", lr, exp_lr);
    st0 = st;
    collect_frame(d, lr, st);
    check_eq("t1_frame_period", 64'(st - st0), 64'd128);
    check_eq("t1_underrun_data", d, 64'd0);
    check_eq("t1_underrun_cnt", 64'(und_cnt - u0), 64'd1);

    // Test 2: H=8, continuous stream of incrementing pairs
    do_reset();
    sr_sel = 2'd3;
    u0 = und_cnt;
    feed_idx = 0;
    feeding = 1'b1;
    fork
      begin
        while (feeding) begin
          s_valid = 1'b1;
          s_left  = 32'hA000_0000 + feed_idx;
          s_right = 32'h5000_0000 + feed_idx;
          if (s_ready) begin
            @(posedge clk);
            #1;
            feed_idx++;
          end else begin
            @(posedge clk);
            #1;
          end
        end
        s_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        check_eq("t2_preload", {63'd0, s_ready}, 64'd0);
        enable(c0, fc0);
        next_fall(ok);
        check_eq("t2_first_fall_cyc", 64'(last_fall_cyc - c0), 64'd16);
        for (int f = 0; f < 10; f++) begin
          collect_frame(d, lr, st);
          check_eq($sformatf("t2_frame%0d", f), d,
                   {32'hA000_0000 + 32'(f), 32'h5000_0000 + 32'(f)});
          if (f == 0) check_eq("t2_load_cyc", 64'(st - c0), 64'd32);
          if (f == 1) check_eq("t2_frame_period", 64'(st - st0), 64'd1024);
          st0 = st;
        end
        check_eq("t2_no_underrun", 64'(und_cnt - u0), 64'd0);
        feeding = 1'b0;
      end
    join

    // Test 3: no samples at all, underrun every frame
    do_reset();
    sr_sel = 2'd0;
    u0 = und_cnt;
    acc = '0;
    enable(c0, fc0);
    next_fall(ok);
    for (int f = 0; f < 5; f++) begin
      collect_frame(d, lr, st);
      acc = acc | d;
    end
    check_eq("t3_sdata_zero", acc, 64'd0);
    check_eq("t3_underrun_cnt", 64'(und_cnt - u0), 64'd5);
    check_eq("t3_underrun_gap", 64'(und_gap), 64'd128);
    check_eq("t3_underrun_width", 64'(und_max_run), 64'd1);
`ifdef IIS_TX_UNDERRUN_CNT_EN
    check_eq("t3_ucnt", {48'd0, underrun_cnt}, 64'd5);
`endif

    // Test 4: rate change mid-frame takes effect at the frame boundary
    do_reset();
    sr_sel = 2'd0;
    enable(c0, fc0);
    skip_to(fc0, 21);
    sr_sel = 2'd2;
    skip_to(fc0, 22);
    g = last_fall_cyc;
    skip_to(fc0, 23);
    check_eq("t4_old_rate", 64'(last_fall_cyc - g), 64'd2);
    skip_to(fc0, 64);
    g = last_fall_cyc;
    skip_to(fc0, 65);
    check_eq("t4_wrap_gap", 64'(last_fall_cyc - g), 64'd2);
    g = last_fall_cyc;
    skip_to(fc0, 66);
    check_eq("t4_new_rate", 64'(last_fall_cyc - g), 64'd8);

    // Test 5: drop en mid-frame, buffered pair retained
    do_reset();
    sr_sel = 2'd1;
    push(32'h1234_5678, 32'hFFFF_FFFF);
    enable(c0, fc0);
    skip_to(fc0, 2);
    push(32'hCAFE_F00D, 32'h0F0F_0F0F);
    skip_to(fc0, 41);
    repeat (2) @(posedge clk);
    #2;
    check_eq("t5_pre_bclk", {63'd0, bclk_o}, 64'd1);
    check_eq("t5_pre_lrck", {63'd0, lrck_o}, 64'd1);
    check_eq("t5_pre_sdata", {63'd0, sdata_o}, 64'd1);
    en = 1'b0;
    @(posedge clk);
    #2;
    check_eq("t5_dis_bclk", {63'd0, bclk_o}, 64'd0);
    check_eq("t5_dis_lrck", {63'd0, lrck_o}, 64'd0);
    check_eq("t5_dis_sdata", {63'd0, sdata_o}, 64'd0);
    repeat (20) @(posedge clk);
    #2;
    check_eq("t5_retained", {63'd0, s_ready}, 64'd0);
    enable(c0, fc0);
    next_fall(ok);
    check_eq("t5_first_fall_cyc", 64'(last_fall_cyc - c0), 64'd4);
    collect_frame(d, lr, st);
    check_eq("t5_load_cyc", 64'(st - c0), 64'd8);
    check_eq("t5_frame_data", d, 64'hCAFE_F00D_0F0F_0F0F);
    check_eq("t5_ready_after", {63'd0, s_ready}, 64'd1);

    // Test 6: asynchronous reset mid-frame discards the buffered pair
    do_reset();
    sr_sel = 2'd1;
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    enable(c0, fc0);
    skip_to(fc0, 2);
    push(32'h1111_1111, 32'h2222_2222);
    skip_to(fc0, 41);
    repeat (2) @(posedge clk);
    #2;
    check_eq("t6_pre_sdata", {63'd0, sdata_o}, 64'd1);
    check_eq("t6_pre_full", {63'd0, s_ready}, 64'd0);
    #1;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check_eq("t6_rst_bclk", {63'd0, bclk_o}, 64'd0);
    check_eq("t6_rst_lrck", {63'd0, lrck_o}, 64'd0);
    check_eq("t6_rst_sdata", {63'd0, sdata_o}, 64'd0);
    check_eq("t6_rst_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    u0 = und_cnt;
    enable(c0, fc0);
    skip_to(fc0, 1);
    collect_frame(d, lr, st);
    check_eq("t6_discarded", d, 64'd0);
    check_eq("t6_underrun", 64'(und_cnt - u0), 64'd1);
`ifdef IIS_TX_UNDERRUN_CNT_EN
    check_eq("t6_ucnt", {48'd0, underrun_cnt}, 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
